// File: rtl/alb_arbiter.sv
// Two-requester round-robin front end for the shared ALB + normalizer datapath.
// One operation in flight: IDLE -> EXEC -> (NORM) -> RESP -> IDLE.
module alb_arbiter #(
    parameter int W     = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req0_sel,
    input  logic [1:0]       req1_sel,
    input  logic [W-1:0]     req0_r,
    input  logic [W-1:0]     req1_r,
    input  logic [W-1:0]     req0_s,
    input  logic [W-1:0]     req1_s,
    input  logic             req0_ci,
    input  logic             req1_ci,
    input  logic             req0_norm,
    input  logic             req1_norm,
    output logic [W-1:0]     alb_r,
    output logic [W-1:0]     alb_s,
    output logic             alb_ci,
    output logic [1:0]       alb_sel,
    input  logic [W-1:0]     alb_f,
    input  logic             alb_co,
    input  logic             alb_vo,
    input  logic             alb_no,
    input  logic             alb_zo,
    output logic [W-1:0]     norm_in,
    output logic             norm_en,
    input  logic [W-1:0]     norm_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_f,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       state;
    logic             rr;        // index of the last granted requester
    logic [1:0]       gnt;
    logic             accept;
    logic [1:0]       op_sel;
    logic [W-1:0]     op_r, op_s;
    logic             op_ci, op_norm, op_id;
    logic [W-1:0]     res;
    logic [3:0]       flg;
    logic [W-1:0]     rsp_f_q;
    logic [3:0]       rsp_flags_q;
    logic             rsp_id_q;
    logic [CNT_W-1:0] ops_done_q;

    always_comb begin
        gnt = 2'b00;
        if (state == S_IDLE) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign accept = |(req_valid & gnt);

    // Response registers load only on entry to RESP so they hold while rsp_valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr          <= 1'b1;
            op_sel      <= '0;
            op_r        <= '0;
            op_s        <= '0;
            op_ci       <= 1'b0;
            op_norm     <= 1'b0;
            op_id       <= 1'b0;
            res         <= '0;
            flg         <= '0;
            rsp_f_q     <= '0;
            rsp_flags_q <= '0;
            rsp_id_q    <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_sel  <= gnt[1] ? req1_sel  : req0_sel;
                        op_r    <= gnt[1] ? req1_r    : req0_r;
                        op_s    <= gnt[1] ? req1_s    : req0_s;
                        op_ci   <= gnt[1] ? req1_ci   : req0_ci;
                        op_norm <= gnt[1] ? req1_norm : req0_norm;
                        op_id   <= gnt[1];
                        rr      <= gnt[1];
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res <= alb_f;
                    flg <= {alb_co, alb_vo, alb_no, alb_zo};
                    if (op_norm) begin
                        state <= S_NORM;
                    end else begin
                        rsp_f_q     <= alb_f;
                        rsp_flags_q <= {alb_co, alb_vo, alb_no, alb_zo};
                        rsp_id_q    <= op_id;
                        state       <= S_RESP;
                    end
                end
                S_NORM: begin
                    res         <= norm_out;
                    rsp_f_q     <= norm_out;
                    rsp_flags_q <= flg;
                    rsp_id_q    <= op_id;
                    state       <= S_RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        ops_done_q <= ops_done_q + CNT_W'(1);
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready = gnt;
    assign alb_r     = op_r;
    assign alb_s     = op_s;
    assign alb_ci    = op_ci;
    assign alb_sel   = op_sel;
    assign norm_in   = res;
    assign norm_en   = (state == S_NORM);
    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state != S_IDLE);
    assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_alb_arbiter.sv
// Bench for alb_arbiter: stand-in ALB/normalizer, transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_alb_arbiter;
    localparam int W     = 10;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0]       req0_sel = '0, req1_sel = '0;
    logic [W-1:0]     req0_r = '0, req1_r = '0, req0_s = '0, req1_s = '0;
    logic             req0_ci = 1'b0, req1_ci = 1'b0, req0_norm = 1'b0, req1_norm = 1'b0;
    logic [W-1:0]     alb_r, alb_s, alb_f, norm_in, norm_out, rsp_f;
    logic             alb_ci, alb_co, alb_vo, alb_no, alb_zo, norm_en;
    logic [1:0]       alb_sel;
    logic             rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
    logic [3:0]       rsp_flags;
    logic [CNT_W-1:0] ops_done;

    int checks = 0;
    int errors = 0;

    alb_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_sel(req0_sel), .req1_sel(req1_sel), .req0_r(req0_r), .req1_r(req1_r),
        .req0_s(req0_s), .req1_s(req1_s), .req0_ci(req0_ci), .req1_ci(req1_ci),
        .req0_norm(req0_norm), .req1_norm(req1_norm),
        .alb_r(alb_r), .alb_s(alb_s), .alb_ci(alb_ci), .alb_sel(alb_sel), .alb_f(alb_f),
        .alb_co(alb_co), .alb_vo(alb_vo), .alb_no(alb_no), .alb_zo(alb_zo),
        .norm_in(norm_in), .norm_en(norm_en), .norm_out(norm_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
        .rsp_flags(rsp_flags), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // External ALB: returns {F, CO, VO, NO, ZO}
    function automatic logic [W+3:0] alb_fn(input logic [1:0] sel, input logic [W-1:0] r,
                                            input logic [W-1:0] s, input logic ci);
        logic [W:0]   sum;
        logic [W-1:0] f, sb;
        logic         co, vo;
        co  = 1'b0;
        vo  = 1'b0;
        sb  = (sel == 2'b11) ? ~s : s;
        sum = {1'b0, r} + {1'b0, sb} + {{W{1'b0}}, ci};
        case (sel)
            2'b00:   f = ~r | s;
            2'b10:   f = ~(r ^ s);
            default: begin
                f  = sum[W-1:0];
                co = sum[W];
                vo = (r[W-1] == sb[W-1]) && (f[W-1] != r[W-1]);
            end
        endcase
        return {f, co, vo, f[W-1], f == '0};
    endfunction

    // Stand-in normalizer: rotate left; garbage when not enabled
    function automatic logic [W-1:0] norm_fn(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    assign {alb_f, alb_co, alb_vo, alb_no, alb_zo} = alb_fn(alb_sel, alb_r, alb_s, alb_ci);
    assign norm_out = norm_en ? norm_fn(norm_in) : {W{1'b1}};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] gnt_of(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Transaction model: one op in flight, age = cycles since acceptance edge
    logic             m_idle = 1'b1, m_rr = 1'b1, m_id = 1'b0;
    int               m_age = 0;
    logic [1:0]       m_sel = '0;
    logic [W-1:0]     m_r = '0, m_s = '0, m_pre = '0, m_f = '0, m_last_f = '0;
    logic             m_ci = 1'b0, m_nrm = 1'b0, m_last_id = 1'b0;
    logic [3:0]       m_fl = '0, m_last_fl = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    always @(negedge clk) begin
        logic [1:0]   e_ready;
        logic         e_valid, e_nen;
        logic [W+3:0] a;
        int           lat;
        e_ready = m_idle ? gnt_of(req_valid, m_rr) : 2'b00;
        lat     = m_nrm ? 3 : 2;
        e_valid = !m_idle && (m_age >= lat);
        e_nen   = !m_idle && m_nrm && (m_age == 2);
        chk("m_req_ready", req_ready, e_ready);
        chk("m_busy", busy, !m_idle);
        chk("m_rsp_valid", rsp_valid, e_valid);
        chk("m_norm_en", norm_en, e_nen);
        chk("m_ops_done", ops_done, m_cnt);
        chk("m_alb_ops", {alb_sel, alb_ci, alb_r, alb_s}, {m_sel, m_ci, m_r, m_s});
        if (e_nen) chk("m_norm_in", norm_in, m_pre);
        if (e_valid) chk("m_rsp", {rsp_id, rsp_flags, rsp_f}, {m_id, m_fl, m_f});
        else         chk("m_rsp_hold", {rsp_id, rsp_flags, rsp_f}, {m_last_id, m_last_fl, m_last_f});

        if (!rst_n) begin
            m_idle = 1'b1; m_rr = 1'b1; m_age = 0; m_cnt = '0; m_nrm = 1'b0;
            m_sel = '0; m_r = '0; m_s = '0; m_ci = 1'b0;
            m_last_f = '0; m_last_fl = '0; m_last_id = 1'b0;
        end else if (m_idle) begin
            if (e_ready != 2'b00) begin
                m_id  = e_ready[1];
                m_rr  = e_ready[1];
                m_sel = m_id ? req1_sel : req0_sel;
                m_r   = m_id ? req1_r : req0_r;
                m_s   = m_id ? req1_s : req0_s;
                m_ci  = m_id ? req1_ci : req0_ci;
                m_nrm = m_id ? req1_norm : req0_norm;
                a     = alb_fn(m_sel, m_r, m_s, m_ci);
                m_pre = a[W+3:4];
                m_fl  = a[3:0];
                m_f   = m_nrm ? norm_fn(m_pre) : m_pre;
                m_idle = 1'b0;
                m_age  = 1;
            end
        end else if (e_valid) begin
            m_last_f = m_f; m_last_fl = m_fl; m_last_id = m_id;
            if (rsp_ready) begin
                m_cnt  = m_cnt + 1'b1;
                m_idle = 1'b1;
            end
        end else begin
            m_age++;
        end
    end

    task automatic set_req(input int id, input logic [1:0] sel, input logic [W-1:0] r,
                           input logic [W-1:0] s, input logic ci, input logic nrm);
        if (id == 0) begin
            req0_sel = sel; req0_r = r; req0_s = s; req0_ci = ci; req0_norm = nrm;
        end else begin
            req1_sel = sel; req1_r = r; req1_s = s; req1_ci = ci; req1_norm = nrm;
        end
    endtask

    // Returns one time unit after the acceptance edge (DUT in EXEC)
    task automatic issue(input int id, input logic [1:0] sel, input logic [W-1:0] r,
                         input logic [W-1:0] s, input logic ci, input logic nrm);
        int n;
        set_req(id, sel, r, s, ci, nrm);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("grant_timeout", n, 0);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    logic [W-1:0] seen_norm_in = '0;
    task automatic wait_rsp(output int lat, output int nn);
        lat = 1;
        nn  = norm_en ? 1 : 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (norm_en) begin nn++; seen_norm_in = norm_in; end
        end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int lat, nn, ng, guard;
        logic [1:0] gl [4];
        logic [1:0] sel;
        logic nrm;

        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_flags, rsp_f}, 0);
        chk("rst_alb", {alb_sel, alb_ci, alb_r, alb_s}, 0);
        chk("rst_norm", {norm_en, norm_in}, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Abort an op in NORM; rr must come back to favour requester 0
        issue(0, 2'b01, 10'h005, 10'h006, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("abort_in_norm", norm_en, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_state", {rsp_valid, busy, norm_en}, 0);
        chk("abort_ops_done", ops_done, 0);
        req_valid = 2'b11; #1;
        chk("abort_first_grant", req_ready, 2'b01);
        req_valid = 2'b00;

        // Single add from requester 0
        issue(0, 2'b01, 10'h00F, 10'h001, 1'b1, 1'b0);
        wait_rsp(lat, nn);
        chk("t1_latency", lat, 2);
        chk("t1_id", rsp_id, 0);
        chk("t1_f", rsp_f, 10'h011);
        chk("t1_flags", rsp_flags, 4'b0000);
        @(posedge clk); #1;
        chk("t1_ops_done", ops_done, 1);

        // (NOT R)|S from requester 1, without and with normalize
        issue(1, 2'b00, 10'h333, 10'h2AA, 1'b0, 1'b0);
        wait_rsp(lat, nn);
        chk("t2_latency", lat, 2);
        chk("t2_id", rsp_id, 1);
        chk("t2_f", rsp_f, 10'h2EE);
        chk("t2_flags", rsp_flags, 4'b0010);
        @(posedge clk); #1;
        issue(1, 2'b00, 10'h333, 10'h2AA, 1'b0, 1'b1);
        wait_rsp(lat, nn);
        chk("t2n_latency", lat, 3);
        chk("t2n_norm_cycles", nn, 1);
        chk("t2n_norm_in", seen_norm_in, 10'h2EE);
        chk("t2n_f", rsp_f, 10'h1DD);
        chk("t2n_flags", rsp_flags, 4'b0010);
        @(posedge clk); #1;
        chk("t2n_ops_done", ops_done, 3);

        // Both requesters continuously valid: grants must alternate
        set_req(0, 2'b11, 10'h200, 10'h00F, 1'b1, 1'b0);
        set_req(1, 2'b11, 10'h200, 10'h00F, 1'b1, 1'b0);
        req_valid = 2'b11;
        ng = 0; guard = 0;
        while (ng < 4 && guard < 100) begin
            @(negedge clk); guard++;
            if (rsp_valid) chk("rr_f", rsp_f, 10'h1F1);
            if (req_ready != 2'b00) begin
                gl[ng] = req_ready; ng++;
                if (ng == 4) begin @(posedge clk); #1; req_valid = 2'b00; end
            end
        end
        req_valid = 2'b00;
        chk("rr_grant_count", ng, 4);
        if (ng == 4) chk("rr_grants", {gl[0], gl[1], gl[2], gl[3]}, 8'b01_10_01_10);
        wait_rsp(lat, nn);
        chk("rr_last_f", rsp_f, 10'h1F1);
        chk("rr_last_flags", rsp_flags, 4'b1100);
        @(posedge clk); #1;
        chk("rr_ops_done", ops_done, 7);

        // Backpressure with the other requester waiting
        rsp_ready = 1'b0;
        issue(0, 2'b10, 10'h155, 10'h0F0, 1'b0, 1'b0);
        wait_rsp(lat, nn);
        set_req(1, 2'b01, 10'h001, 10'h001, 1'b0, 1'b0);
        req_valid = 2'b10;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_f", rsp_f, 10'h25A);
            chk("bp_flags", rsp_flags, 4'b0010);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("bp_ops_done", ops_done, 8);
        @(posedge clk); #1;
        chk("bp_ops_done_once", ops_done, 8);

        // Eight more ops, counter wraps at 16
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i);
            nrm = (i >= 4);
            issue(i % 2, sel, 10'(i * 37 + 5), 10'(i * 91), i[0], nrm);
            wait_rsp(lat, nn);
            chk("fill_latency", lat, nrm ? 3 : 2);
            @(posedge clk); #1;
        end
        chk("wrap_ops_done", ops_done, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/alb_arbiter.md
Name: alb_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 10-bit ALB datapath (`alb` + `normalizer`).
- Accepts one operation at a time: op select, R, S, CI and a normalize request.
- Drives the combinational ALB and normalizer from registered operands, captures F and the CO/VO/NO/ZO flags, and returns the result on a tagged response channel.
- Sits between the requesting units and the ALB/normalizer instances, which stay outside this block.

Parameters:
- W, 10, datapath width of R, S and F.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept, one-hot or zero.
- req0_sel / req1_sel  in  2 each  ALB op select (00 NOT R|S, 01 R+S+CI, 10 NOT(R^S), 11 R-S-1+CI).
- req0_r / req1_r  in  W each  operand R.
- req0_s / req1_s  in  W each  operand S.
- req0_ci / req1_ci  in  1 each  carry in.
- req0_norm / req1_norm  in  1 each  1 = pass the result through the normalizer.
- alb_r, alb_s  out  W  operands to the ALB.
- alb_ci  out  1  carry to the ALB.
- alb_sel  out  2  op select to the ALB.
- alb_f  in  W  ALB result.
- alb_co, alb_vo, alb_no, alb_zo  in  1 each  ALB flags.
- norm_in  out  W  value to the normalizer.
- norm_en  out  1  normalizer enable.
- norm_out  in  W  normalizer result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index the response belongs to.
- rsp_f  out  W  result.
- rsp_flags  out  4  {CO,VO,NO,ZO} captured from the ALB.
- busy  out  1  FSM not in IDLE.
- ops_done  out  CNT_W  count of completed responses.

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE, rr pointer=1 so requester 0 wins first.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_f, rsp_flags, busy, ops_done.
  - alb_* outputs 0; norm_en=0; norm_in=0.
  - Reset mid-operation aborts it: no response is issued and ops_done is unchanged.
- FSM states: IDLE, EXEC, NORM, RESP.
- IDLE arbitration:
  - req_ready is combinational and asserted only in IDLE, only for the granted requester.
  - Grant goes to the single requester with req_valid high.
  - If both are valid, grant goes to the requester not equal to the rr pointer. The pointer updates to the granted index on acceptance.
  - Acceptance = req_valid[i] & req_ready[i] at a clk edge. On that edge: latch sel/R/S/CI/norm and the id, then go to EXEC.
- EXEC (1 cycle):
  - alb_* outputs are driven from the latched operands for the whole cycle.
  - At cycle end, capture alb_f into the result register and the four flags into rsp_flags.
  - Next state is NORM if norm=1, else RESP.
- NORM (1 cycle):
  - norm_in = captured F, norm_en=1. norm_en is 0 in every other state.
  - At cycle end, the result register takes norm_out; flags are unchanged.
  - Next state is RESP.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_f and rsp_flags stable until rsp_ready is high at a clk edge.
  - On that edge: ops_done increments (wraps modulo 2^CNT_W) and the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake. This gives a minimum 1 IDLE cycle between operations.
- Latency from the acceptance edge to the first rsp_valid cycle: 2 cycles without normalize, 3 with normalize.
- Between operations, alb_* outputs hold their last values; rsp_* hold their last values while rsp_valid=0.
- Requests with req_valid high while busy are simply not accepted, and the requester must hold them.
- busy=1 in EXEC, NORM and RESP.
- All result arithmetic is done by the external ALB; this block performs no arithmetic except on ops_done.

Test Plan:
- Single op, requester 0: sel=01, R=0x00F, S=0x001, CI=1, norm=0 -> rsp_valid 2 cycles after acceptance, rsp_id=0, rsp_f=0x011, CO=0, ZO=0, ops_done=1.
- Op 00, requester 1: R=0x333, S=0x2AA, CI=0, norm=0 -> rsp_f=0x2EE, NO=1, rsp_id=1. Repeat with norm=1 -> norm_en high for exactly 1 cycle with norm_in=0x2EE, rsp_f=norm_out sampled in that cycle, flags identical to the norm=0 run, latency 3.
- Both requesters valid every cycle with sel=11, R=0x200, S=0x00F, CI=1 -> grants alternate 0,1,0,1; each rsp_f=0x1F1; ops_done=4 after 4 responses.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid/rsp_f/rsp_flags stable throughout, req_ready stays 0, then one handshake and ops_done increments once.
- Reset in NORM state (rst_n low 1 cycle) -> next cycle: rsp_valid=0, busy=0, norm_en=0, ops_done unchanged, requester 0 granted first afterwards.
- ops_done wrap: with CNT_W=4, complete 16 ops -> ops_done returns to 0.
